// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the OTTER register file's single write port.
// Round-robin shares the port between NREQ requesters using valid/ready handshakes.
// A hardware sweep can also zero x1..x31.
// All register-file drive signals are registered. The register file commits
// them on the falling edge of the following cycle.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [5*NREQ-1:0] req_adr_i,
  input  logic [DW*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              rf_en_o,
  output logic [4:0]        rf_w_adr_o,
  output logic [DW-1:0]     rf_w_data_o,
  output logic [1:0]        grant_id_o
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e     state_q;
  logic [4:0] cnt_q;    // register currently being zeroed by the sweep
  logic [1:0] ptr_q;    // highest-priority requester for the next grant

  logic       grant_c;
  logic [1:0] sel_c;

  // Adds off to base modulo NREQ. Both operands are below NREQ, so a single
  // wrap is enough.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return 2'(sum);
  endfunction

  // Pick the first valid requester at or after ptr. Nothing is granted
  // during a sweep or in the cycle a sweep is requested.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    grant_c     = 1'b0;
    sel_c       = '0;
    req_ready_o = '0;
    if (state_q == IDLE && !clr_start_i) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!grant_c && req_valid_i[rr_index(ptr_q, k)]) begin
          grant_c = 1'b1;
          sel_c   = rr_index(ptr_q, k);
        end
      end
      if (grant_c) req_ready_o[sel_c] = 1'b1;
    end
  end

  // Sequencer: register the accepted write, or step the clear sweep.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments. Each register then
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_id_o  <= '0;
      clr_busy_o  <= 1'b0;
      rf_en_o     <= 1'b0;
      rf_w_adr_o  <= '0;
      rf_w_data_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            // Preload the first sweep write so x1 is driven in the first
            // CLEAR cycle.
            state_q     <= CLEAR;
            cnt_q       <= 5'd1;
            clr_busy_o  <= 1'b1;
            rf_en_o     <= 1'b1;
            rf_w_adr_o  <= 5'd1;
            rf_w_data_o <= '0;
          end else if (grant_c) begin
            ptr_q       <= rr_index(sel_c, 1);
            grant_id_o  <= sel_c;
            rf_w_adr_o  <= req_adr_i[5*sel_c +: 5];
            rf_w_data_o <= req_data_i[DW*sel_c +: DW];
            // A write to x0 is consumed but never reaches the register file.
            rf_en_o     <= (req_adr_i[5*sel_c +: 5] != 5'd0);
          end else begin
            rf_en_o <= 1'b0;
          end
        end
        CLEAR: begin
          // clr_start_i is deliberately ignored here, so the sweep never restarts.
          if (cnt_q == 5'd31) begin
            state_q    <= IDLE;
            clr_busy_o <= 1'b0;
            rf_en_o    <= 1'b0;
          end else begin
            cnt_q       <= cnt_q + 5'd1;
            rf_en_o     <= 1'b1;
            rf_w_adr_o  <= cnt_q + 5'd1;
            rf_w_data_o <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// A behavioural model of the round-robin, the x0 rule and the 31-write sweep
// predicts every output. A register-file array is fed from the DUT outputs on
// the falling edge and compared against the model's view of the register contents.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [5*NREQ-1:0]   req_adr;
  logic [DW*NREQ-1:0]  req_data;
  logic                clr_start, clr_busy, rf_en;
  logic [4:0]          rf_w_adr;
  logic [DW-1:0]       rf_w_data;
  logic [1:0]          grant_id;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_adr_i(req_adr), .req_data_i(req_data),
    .req_ready_o(req_ready), .clr_start_i(clr_start), .clr_busy_o(clr_busy),
    .rf_en_o(rf_en), .rf_w_adr_o(rf_w_adr), .rf_w_data_o(rf_w_data),
    .grant_id_o(grant_id)
  );

  // Register file driven by the DUT. It commits on the falling edge and also
  // accepts x0, so any stray enable for x0 shows up.
  logic [DW-1:0] rf_dut [32] = '{default: '0};
  int            clr_writes = 0;
  always @(negedge clk) begin
    if (rf_en === 1'b1) rf_dut[rf_w_adr] <= rf_w_data;
    if (rf_en === 1'b1 && clr_busy === 1'b1) clr_writes <= clr_writes + 1;
  end

  // Behavioural model state
  logic [DW-1:0] rf_mdl [32] = '{default: '0};
  int            m_ptr    = 0;
  logic          m_busy   = 1'b0;
  logic          exp_en   = 1'b0;
  logic [4:0]    exp_adr  = '0;
  logic [DW-1:0] exp_data = '0;
  logic [1:0]    exp_gid  = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5*NREQ-1:0] adr_at(input int i, input logic [4:0] a);
    logic [5*NREQ-1:0] r;
    r = '0;
    r[5*i +: 5] = a;
    return r;
  endfunction

  function automatic logic [DW*NREQ-1:0] data_at(input int i, input logic [DW-1:0] d);
    logic [DW*NREQ-1:0] r;
    r = '0;
    r[DW*i +: DW] = d;
    return r;
  endfunction

  // One clock cycle. It is entered 1 time unit after a rising edge and leaves
  // 1 time unit after the next one.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [5*NREQ-1:0] a,
                       input logic [DW*NREQ-1:0] d, input logic cs, input logic r);
    logic [NREQ-1:0] m_ready;
    int g;
    int bad;
    req_valid = v; req_adr = a; req_data = d; clr_start = cs; rst = r;
    // The write now on the outputs commits at this cycle's falling edge.
    if (exp_en) rf_mdl[exp_adr] = exp_data;
    // Round-robin: scan from the pointer, wrapping around the requesters.
    g = -1;
    m_ready = '0;
    if (!m_busy && !cs)
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    if (g >= 0) m_ready[g] = 1'b1;
    #1;
    if (!r) check("req_ready", 32'(req_ready), 32'(m_ready));
    // Predict the registered outputs for the next cycle.
    if (r) begin
      m_busy = 1'b0; m_ptr = 0;
      exp_en = 1'b0; exp_adr = '0; exp_data = '0; exp_gid = '0;
    end else if (m_busy) begin
      if (exp_adr == 5'd31) begin
        m_busy = 1'b0; exp_en = 1'b0;
      end else begin
        exp_adr = exp_adr + 5'd1; exp_en = 1'b1; exp_data = '0;
      end
    end else if (cs) begin
      m_busy = 1'b1; exp_en = 1'b1; exp_adr = 5'd1; exp_data = '0;
    end else if (g >= 0) begin
      exp_adr  = a[5*g +: 5];
      exp_data = d[DW*g +: DW];
      exp_en   = (exp_adr != 5'd0);
      exp_gid  = 2'(g);
      m_ptr    = (g + 1) % NREQ;
    end else begin
      exp_en = 1'b0;
    end
    #4;
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf_dut[i] !== rf_mdl[i]) bad++;
    check("rf_contents_bad_count", 32'(bad), 32'd0);
    @(posedge clk); #1;
    check("rf_en", 32'(rf_en), 32'(exp_en));
    check("rf_w_adr", 32'(rf_w_adr), 32'(exp_adr));
    check("rf_w_data", rf_w_data, exp_data);
    check("grant_id", 32'(grant_id), 32'(exp_gid));
    check("clr_busy", 32'(clr_busy), 32'(m_busy));
  endtask

  task automatic idle();
    cycle('0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++)
      cycle(3'b001, adr_at(0, 5'(i)), data_at(0, 32'hA500_0000 | 32'(i)), 1'b0, 1'b0);
    idle();
  endtask

  int base;
  int cnt;

  initial begin
    req_valid = '0; req_adr = '0; req_data = '0; clr_start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    cycle('0, '0, '0, 1'b0, 1'b1);
    cycle('0, '0, '0, 1'b0, 1'b1);
    check("reset_rf_en", 32'(rf_en), 32'd0);
    check("reset_grant_id", 32'(grant_id), 32'd0);

    // Single write of 0xDEADBEEF to x5 by requester 0
    cycle(3'b001, adr_at(0, 5'd5), data_at(0, 32'hDEADBEEF), 1'b0, 1'b0);
    check("single_rf_w_adr", 32'(rf_w_adr), 32'd5);
    idle();
    check("x5_after_write", rf_dut[5], 32'hDEADBEEF);

    // Three requesters all valid; grants follow 0,1,2,0,1,2 from ptr=0.
    cycle('0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333, 32'h2222, 32'h1111}, 1'b0, 1'b0);
      check("rr_order_grant_id", 32'(grant_id), 32'(k % 3));
      check("rr_order_rf_en", 32'(rf_en), 32'd1);
    end

    // A write to x0 completes the handshake and moves the pointer, but must
    // not raise rf_en.
    cycle(3'b010, adr_at(1, 5'd0), data_at(1, 32'h1234), 1'b0, 1'b0);
    check("x0_rf_en", 32'(rf_en), 32'd0);
    check("x0_grant_id", 32'(grant_id), 32'd1);
    idle();
    check("x0_stays_zero", rf_dut[0], 32'd0);

    // Clear sweep while requester 1 is waiting
    preload();
    base = clr_writes;
    cycle(3'b010, adr_at(1, 5'd7), data_at(1, 32'd77), 1'b1, 1'b0);
    for (int k = 0; k < 31; k++) cycle(3'b010, adr_at(1, 5'd7), data_at(1, 32'd77), 1'b0, 1'b0);
    check("clear_busy_falls", 32'(clr_busy), 32'd0);
    check("clear_write_count", 32'(clr_writes - base), 32'd31);
    cnt = 0;
    for (int i = 1; i < 32; i++) if (rf_dut[i] != 0) cnt++;
    check("clear_all_zero", 32'(cnt), 32'd0);
    cycle(3'b010, adr_at(1, 5'd7), data_at(1, 32'd77), 1'b0, 1'b0);
    check("after_clear_grant_adr", 32'(rf_w_adr), 32'd7);

    // Reset partway through a sweep
    preload();
    cycle('0, '0, '0, 1'b1, 1'b0);
    for (int k = 1; k < 10; k++) idle();
    cycle('0, '0, '0, 1'b0, 1'b1);
    check("mid_clear_rst_busy", 32'(clr_busy), 32'd0);
    check("mid_clear_rst_en", 32'(rf_en), 32'd0);
    cnt = 0;
    for (int i = 11; i < 32; i++) if (rf_dut[i] != 0) cnt++;
    check("mid_clear_upper_kept", 32'(cnt), 32'd21);
    cycle(3'b110, {5'd9, 5'd8, 5'd0}, {32'h9, 32'h8, 32'h0}, 1'b0, 1'b0);
    check("ptr_reset_grant_id", 32'(grant_id), 32'd1);

    // A second clr_start inside the sweep must not restart it.
    base = clr_writes;
    cycle('0, '0, '0, 1'b1, 1'b0);
    for (int k = 1; k < 32; k++) cycle('0, '0, '0, (k == 5), 1'b0);
    check("restart_ignored_busy", 32'(clr_busy), 32'd0);
    check("restart_ignored_writes", 32'(clr_writes - base), 32'd31);

    // Random traffic
    for (int k = 0; k < 600; k++)
      cycle(3'($urandom_range(0, 7)), 15'($urandom), {$urandom, $urandom, $urandom},
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
